bin_to_bcd_seq: RTL and testbench

Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, with a valid/ready handshake on both sides. It replaces the ROM lookup and divider datapaths that feed the multi-digit seven-segment display path. It supports any input width and digit count, detects overflow in-line, and optionally produces a leading-zero blanking mask for the display controller.

---
 rtl/bcd_pkg.sv | 36 +++
 rtl/bcd_digit_adj.sv | 24 ++
 rtl/bin_to_bcd_seq.sv | 167 ++++++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// ============================================================================
// Module : bcd_pkg
// Brief  : Shared types and constants for the sequential binary-to-BCD
//          converter (FSM states, digit width, add-3 threshold).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_pkg;

    // Width of one packed BCD digit
    localparam int BCD_DIGIT_W = 4;

    // Digits at or above this value get +3 before each shift
    localparam logic [BCD_DIGIT_W-1:0] ADD3_THRESHOLD = 4'd5;

    // Converter control states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd_state_t;

    // True when a BIN_W-bit input can exceed the largest DIGITS-digit value,
    // i.e. 2^bin_w > 10^digits. Compared in log10 space so that wide inputs
    // never overflow an integer; the two sides are never exactly equal for
    // positive integers, so the rounding of log10(2) cannot flip the answer.
    function automatic bit overflow_possible(input int bin_w, input int digits);
        real w_log;
        w_log = real'(bin_w) * 0.30102999566398120;
        return (w_log > real'(digits));
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit_adj.sv
// ============================================================================
// Module : bcd_digit_adj
// Brief  : Combinational double-dabble digit correction: adds 3 to a BCD
//          digit that is 5 or more so the following left shift carries
//          correctly into the next decimal digit.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] i_digit,
    output logic [BCD_DIGIT_W-1:0] o_digit
);

    // Add 3 when the digit would reach 10 or more after doubling
    always_comb begin
        o_digit = (i_digit >= ADD3_THRESHOLD) ? (i_digit + BCD_DIGIT_W'(3)) : i_digit;
    end

endmodule

`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
// ============================================================================
// Module : bin_to_bcd_seq
// Brief  : Sequential shift-and-add-3 binary-to-BCD converter with
//          valid/ready handshakes, in-line overflow detection (result is the
//          input modulo 10^DIGITS) and an optional leading-zero blank mask.
//          Optional feature macro: BIN_TO_BCD_BLANK_EN (blank mask enable).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_WIDTH = 14,
    parameter int DIGITS    = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [BIN_WIDTH-1:0]         bin_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
    output logic                         overflow,
    output logic [DIGITS-1:0]            blank
);

    localparam int  CNT_W    = $clog2(BIN_WIDTH + 1);
    localparam int  BCD_W    = BCD_DIGIT_W * DIGITS;
    localparam bit  OVF_LIVE = overflow_possible(BIN_WIDTH, DIGITS);

    localparam logic [CNT_W-1:0] c_last_iter = CNT_W'(BIN_WIDTH - 1);

    bcd_state_t         r_state;
    logic [BIN_WIDTH-1:0] r_bin;
    logic [BCD_W-1:0]   r_bcd;
    logic               r_ovf;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [BCD_W-1:0]   r_bcd_out;
    logic               r_ovf_out;

    logic [BCD_W-1:0]     w_adj;
    logic [BCD_W-1:0]     w_bcd_next;
    logic [BIN_WIDTH-1:0] w_bin_next;
    logic                 w_shift_out;
    logic                 w_ovf_next;
    logic                 w_last_iter;

    // One add-3 corrector per decimal digit
    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_digit
            bcd_digit_adj u_adj (
                .i_digit (r_bcd[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .o_digit (w_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
            );
        end
    endgenerate

    // Shift {bcd, bin} left by one; the bit leaving the top digit is a
    // carry worth 10^DIGITS and is dropped, leaving the value mod 10^DIGITS
    assign w_shift_out = w_adj[BCD_W-1];
    assign w_bcd_next  = {w_adj[BCD_W-2:0], r_bin[BIN_WIDTH-1]};
    assign w_bin_next  = r_bin << 1;
    assign w_last_iter = (r_cnt == c_last_iter);

    // Overflow can only occur when the input range exceeds the digit range
    generate
        if (OVF_LIVE) begin : g_ovf_live
            assign w_ovf_next = r_ovf | w_shift_out;
        end else begin : g_ovf_const
            assign w_ovf_next = 1'b0;
        end
    endgenerate

    // Control FSM with registered handshake outputs and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_bin       <= '0;
            r_bcd       <= '0;
            r_ovf       <= 1'b0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_bcd_out   <= '0;
            r_ovf_out   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_bin      <= bin_in;
                        r_bcd      <= '0;
                        r_ovf      <= 1'b0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_bin <= w_bin_next;
                    r_bcd <= w_bcd_next;
                    r_ovf <= w_ovf_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last_iter) begin
                        r_bcd_out   <= w_bcd_next;
                        r_ovf_out   <= w_ovf_next;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

`ifdef BIN_TO_BCD_BLANK_EN
    logic [DIGITS-1:0] w_blank_next;
    logic [DIGITS-1:0] r_blank;

    // Digit i blanks when it and every higher digit are zero; units never
    // blank, and an overflowed (truncated) result is shown in full
    always_comb begin
        logic w_hi_zero;
        w_blank_next = '0;
        w_hi_zero    = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            w_hi_zero       = w_hi_zero & (w_bcd_next[i*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
            w_blank_next[i] = w_hi_zero & ~w_ovf_next;
        end
    end

    // Capture the mask together with the final result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blank <= '0;
        end else if (r_state == SHIFT && w_last_iter) begin
            r_blank <= w_blank_next;
        end
    end

    assign blank = r_blank;
`else
    assign blank = '0;
`endif

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign bcd_out   = r_bcd_out;
    assign overflow  = r_ovf_out;

endmodule

`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
// ============================================================================
// Module : tb_bin_to_bcd_seq
// Brief  : Self-checking bench for bin_to_bcd_seq: default instance checked
//          every cycle against a decimal-arithmetic model, plus an 8-bit /
//          3-digit instance swept over its full input range.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bin_to_bcd_seq;

`ifdef BIN_TO_BCD_BLANK_EN
    localparam bit BLANK_ON = 1'b1;
`else
    localparam bit BLANK_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;

    logic        in_valid, in_ready, out_valid, out_ready, overflow;
    logic [13:0] bin_in;
    logic [15:0] bcd_out;
    logic [3:0]  blank;

    logic        in_valid2, in_ready2, out_valid2, out_ready2, overflow2;
    logic [7:0]  bin_in2;
    logic [11:0] bcd_out2;
    logic [2:0]  blank2;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    int q_val[$];
    int q_due[$];

    bin_to_bcd_seq #(.BIN_WIDTH(14), .DIGITS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .bin_in(bin_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .bcd_out(bcd_out), .overflow(overflow), .blank(blank)
    );

    bin_to_bcd_seq #(.BIN_WIDTH(8), .DIGITS(3)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid2), .in_ready(in_ready2), .bin_in(bin_in2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .bcd_out(bcd_out2), .overflow(overflow2), .blank(blank2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- decimal reference model ----------------
    function automatic int pow10(input int d);
        int r = 1;
        for (int i = 0; i < d; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [15:0] exp_bcd(input int v, input int d);
        logic [15:0] r = '0;
        int m = v % pow10(d);
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    function automatic logic exp_ovf(input int v, input int d);
        return (v > pow10(d) - 1);
    endfunction

    function automatic logic [3:0] exp_blank(input int v, input int d);
        logic [3:0] r = '0;
        if (BLANK_ON && !exp_ovf(v, d))
            for (int i = 1; i < d; i++) r[i] = (v < pow10(i));
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_chk++;
        n_err++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    // ---------------- per-cycle compare for the default instance ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            q_val.delete();
            q_due.delete();
            chk("rst_in_ready", in_ready, 1);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_bcd", bcd_out, 0);
            chk("rst_ovf", overflow, 0);
            chk("rst_blank", blank, 0);
        end else begin
            chk("in_ready", in_ready, q_val.size() == 0);
            chk("out_valid", out_valid, (q_val.size() > 0) && (cyc >= q_due[0]));
            if (out_valid && q_val.size() > 0) begin
                chk("bcd", bcd_out, exp_bcd(q_val[0], 4));
                chk("ovf", overflow, exp_ovf(q_val[0], 4));
                chk("blank", blank, exp_blank(q_val[0], 4));
                if (out_ready) begin
                    void'(q_val.pop_front());
                    void'(q_due.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                q_val.push_back(int'(bin_in));
                q_due.push_back(cyc + 1 + 14);
            end
        end
    end

    // One conversion on the default instance; stall = cycles out_ready is held
    // low after out_valid (0 = ready already high when the result appears)
    task automatic conv(input int v, input int stall,
                        output logic [15:0] b, output logic o, output logic [3:0] bl);
        int n;
        b = '0; o = 1'b0; bl = '0;
        n = 0;
        while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
        if (!in_ready) begin timeout("accept"); return; end
        in_valid  = 1'b1;
        bin_in    = 14'(v);
        out_ready = (stall == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
        if (!out_valid) begin timeout("out_valid"); out_ready = 1'b0; return; end
        b = bcd_out; o = overflow; bl = blank;
        if (stall > 0) begin
            for (int k = 0; k < stall; k++) begin
                @(posedge clk); #1;
                in_valid = k[0];
                bin_in   = 14'($urandom_range(0, 16383));
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    logic [15:0] b;
    logic        o;
    logic [3:0]  bl;

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; bin_in = '0;
        in_valid2 = 1'b0; out_ready2 = 1'b0; bin_in2 = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Largest non-overflowing value, with a 20-cycle consumer stall
        conv(9999, 20, b, o, bl);
        chk("9999_bcd", b, 16'h9999);
        chk("9999_ovf", o, 0);
        chk("9999_blank", bl, 4'b0000);

        // Overflow boundary and maximum input, consumed the cycle they appear
        conv(10000, 0, b, o, bl);
        chk("10000_bcd", b, 16'h0000);
        chk("10000_ovf", o, 1);
        chk("10000_blank", bl, 4'b0000);
        conv(16383, 0, b, o, bl);
        chk("16383_bcd", b, 16'h6383);
        chk("16383_ovf", o, 1);

        // Leading-zero blanking
        conv(0, 0, b, o, bl);
        chk("0_bcd", b, 16'h0000);
        chk("0_blank", bl, BLANK_ON ? 4'b1110 : 4'b0000);
        conv(42, 0, b, o, bl);
        chk("42_bcd", b, 16'h0042);
        chk("42_blank", bl, BLANK_ON ? 4'b1100 : 4'b0000);

        // Reset asserted during the 7th iteration of 1234
        in_valid = 1'b1; bin_in = 14'd1234; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk("abort_bcd", bcd_out, 0);
        chk("abort_valid", out_valid, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        conv(1234, 0, b, o, bl);
        chk("1234_bcd", b, 16'h1234);
        chk("1234_ovf", o, 0);
        chk("1234_blank", bl, BLANK_ON ? 4'b0000 : 4'b0000);

        // Full sweep of the 8-bit / 3-digit instance
        for (int v = 0; v < 256; v++) begin
            int n;
            n = 0;
            while (!in_ready2 && n < 50) begin @(posedge clk); #1; n++; end
            if (!in_ready2) begin timeout("accept8"); break; end
            in_valid2 = 1'b1; bin_in2 = 8'(v); out_ready2 = 1'b1;
            @(posedge clk); #1;
            in_valid2 = 1'b0;
            n = 0;
            while (!out_valid2 && n < 30) begin @(posedge clk); #1; n++; end
            if (!out_valid2) begin timeout("out_valid8"); break; end
            chk("lat8", n, 8);
            chk("bcd8", bcd_out2, exp_bcd(v, 3));
            chk("ovf8", overflow2, 0);
            chk("blank8", blank2, exp_blank(v, 3));
            @(posedge clk); #1;
        end
        out_ready2 = 1'b0;
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
